// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame arbiter.
// Header bytes are only emitted when UART_FRAME_HEADER_EN is defined.
package uart_frame_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARB,
      LOAD,
      START,
      START_WAIT,
      WAIT,
      NEXT,
      DONE
   } state_t;

   localparam logic [7:0] HDR_SYNC  = 8'hA5;
   localparam int         HDR_LEN   = 2;
   localparam int         HDR_IDX_W = 4;

endpackage

// File: rtl/uart_frame_arbiter_if.sv
// Requester/UART bundle for the frame arbiter; master is the arbiter side,
// slave is the requesters plus the external uart_tx.
interface uart_frame_arbiter_if #(
   parameter int NUM_REQ   = 2,
   parameter int DATA_SIZE = 8,
   parameter int LEN_SIZE  = 4
);

   logic [NUM_REQ-1:0]           req;
   logic [NUM_REQ*LEN_SIZE-1:0]  len;
   logic [NUM_REQ*DATA_SIZE-1:0] data;
   logic [NUM_REQ-1:0]           grant;
   logic [LEN_SIZE-1:0]          byteIdx;
   logic [NUM_REQ-1:0]           done;
   logic                         txValid;
   logic [DATA_SIZE-1:0]         txData;
   logic                         txReady;

   modport master (
      input  req, len, data, txReady,
      output grant, byteIdx, done, txValid, txData
   );

   modport slave (
      output req, len, data, txReady,
      input  grant, byteIdx, done, txValid, txData
   );

endinterface

// File: rtl/uart_frame_arbiter_rr_arbiter.sv
// Round-robin pick: search starts one past the last owner and wraps.
// Purely combinational; the caller registers the result.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any
);

   always_comb begin
      int v_pos;
      v_pos   = 0;
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         v_pos = (int'(i_last) + k) % NUM_REQ;
         if (!o_any && i_req[v_pos]) begin
            o_any          = 1'b1;
            o_grant[v_pos] = 1'b1;
            o_idx          = IDX_W'(v_pos);
         end
      end
   end

endmodule

// File: rtl/uart_frame_arbiter.sv
// Multiplexes framed byte streams from several requesters onto one uart_tx.
// Define UART_FRAME_HEADER_EN to prefix each frame with a 2-byte header.
module uart_frame_arbiter
   import uart_frame_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int DATA_SIZE = 8,
   parameter int LEN_SIZE  = 4
) (
   input  logic                         i_clock,
   input  logic                         i_rstN,
   input  logic [NUM_REQ-1:0]           i_req,
   input  logic [NUM_REQ*LEN_SIZE-1:0]  i_len,
   input  logic [NUM_REQ*DATA_SIZE-1:0] i_data,
   output logic [NUM_REQ-1:0]           o_grant,
   output logic [LEN_SIZE-1:0]          o_byteIdx,
   output logic [NUM_REQ-1:0]           o_done,
   output logic                         o_txValid,
   output logic [DATA_SIZE-1:0]         o_txData,
   input  logic                         i_txReady
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int SEQ_W = LEN_SIZE + 2;
`ifdef UART_FRAME_HEADER_EN
   localparam int HDR_N = HDR_LEN;
`else
   localparam int HDR_N = 0;
`endif

   state_t               r_state;
   state_t               w_next;
   logic [NUM_REQ-1:0]   r_grant;
   logic [IDX_W-1:0]     r_owner;
   logic [IDX_W-1:0]     r_last;
   logic [LEN_SIZE-1:0]  r_len;
   logic [LEN_SIZE-1:0]  r_byteIdx;
   logic [SEQ_W-1:0]     r_seq;
   logic [DATA_SIZE-1:0] r_txData;

   logic [NUM_REQ-1:0]   w_rrGrant;
   logic [IDX_W-1:0]     w_rrIdx;
   logic                 w_rrAny;
   logic [LEN_SIZE-1:0]  w_ownerLen;
   logic [DATA_SIZE-1:0] w_ownerData;
   logic [DATA_SIZE-1:0] w_byte;
   logic [SEQ_W-1:0]     w_total;
   logic                 w_lastByte;
   logic                 w_inHdr;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .i_req   (i_req),
      .i_last  (r_last),
      .o_grant (w_rrGrant),
      .o_idx   (w_rrIdx),
      .o_any   (w_rrAny)
   );

   assign w_ownerLen  = i_len[w_rrIdx*LEN_SIZE +: LEN_SIZE];
   assign w_ownerData = i_data[r_owner*DATA_SIZE +: DATA_SIZE];
   assign w_total     = SEQ_W'(HDR_N) + SEQ_W'(r_len);
   assign w_lastByte  = (r_seq + 1'b1) == w_total;

   // r_seq walks header then payload; r_byteIdx only tracks payload
`ifdef UART_FRAME_HEADER_EN
   assign w_inHdr = r_seq < SEQ_W'(HDR_LEN);
   always_comb begin
      w_byte = w_ownerData;
      if (r_seq == '0)
         w_byte = DATA_SIZE'(HDR_SYNC);
      else if (r_seq == SEQ_W'(1))
         w_byte = DATA_SIZE'({r_len, HDR_IDX_W'(r_owner)});
   end
`else
   assign w_inHdr = 1'b0;
   assign w_byte  = w_ownerData;
`endif

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:
            if (|i_req && i_txReady) w_next = ARB;
         ARB:
            if (!w_rrAny)
               w_next = IDLE;
            else if (w_ownerLen == '0 && HDR_N == 0)
               w_next = DONE;
            else
               w_next = LOAD;
         LOAD:       w_next = START;
         START:      w_next = START_WAIT;
         START_WAIT:
            if (!i_txReady) w_next = WAIT;
         WAIT:
            if (i_txReady) w_next = NEXT;
         NEXT:
            w_next = w_lastByte ? DONE : LOAD;
         DONE:       w_next = IDLE;
         default:    w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (!i_rstN) begin
         r_state   <= IDLE;
         r_grant   <= '0;
         r_owner   <= '0;
         r_last    <= IDX_W'(NUM_REQ - 1);
         r_len     <= '0;
         r_byteIdx <= '0;
         r_seq     <= '0;
         r_txData  <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            ARB:
               if (w_rrAny) begin
                  r_grant   <= w_rrGrant;
                  r_owner   <= w_rrIdx;
                  r_len     <= w_ownerLen;
                  r_byteIdx <= '0;
                  r_seq     <= '0;
               end
            LOAD:
               r_txData <= w_byte;
            NEXT: begin
               r_seq <= r_seq + 1'b1;
               if (!w_inHdr && !w_lastByte)
                  r_byteIdx <= r_byteIdx + 1'b1;
            end
            DONE: begin
               r_last  <= r_owner;
               r_grant <= '0;
            end
            default: ;
         endcase
      end
   end

   assign o_grant   = r_grant;
   assign o_byteIdx = r_byteIdx;
   assign o_txData  = r_txData;
   assign o_txValid = (r_state == START);
   assign o_done    = (r_state == DONE) ? r_grant : '0;

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Self-checking bench for uart_frame_arbiter with a uart_tx model
// and a frame-level round-robin reference.
module tb_uart_frame_arbiter;

   localparam int N  = 2;
   localparam int DW = 8;
   localparam int LW = 4;
`ifdef UART_FRAME_HEADER_EN
   localparam int HN = 2;
`else
   localparam int HN = 0;
`endif

   logic clk = 1'b0;
   logic rstN = 1'b0;
   always #5 clk = ~clk;

   uart_frame_arbiter_if #(
      .NUM_REQ   (N),
      .DATA_SIZE (DW),
      .LEN_SIZE  (LW)
   ) bus ();

   uart_frame_arbiter #(
      .NUM_REQ   (N),
      .DATA_SIZE (DW),
      .LEN_SIZE  (LW)
   ) dut (
      .i_clock   (clk),
      .i_rstN    (rstN),
      .i_req     (bus.req),
      .i_len     (bus.len),
      .i_data    (bus.data),
      .o_grant   (bus.grant),
      .o_byteIdx (bus.byteIdx),
      .o_done    (bus.done),
      .o_txValid (bus.txValid),
      .o_txData  (bus.txData),
      .i_txReady (bus.txReady)
   );

   logic [DW-1:0] mem [N][16];
   int            lens [N];

   // requesters present the byte at the index the arbiter asks for
   always_comb begin
      bus.data = '0;
      for (int r = 0; r < N; r++)
         bus.data[r*DW +: DW] = mem[r][bus.byteIdx];
   end

   int            n_tests = 0;
   int            n_fail = 0;
   logic [DW-1:0] got_q [$];
   int            done_q [$];
   int            busy_force = 0;
   int            rst_epoch = 0;
   int            m_last = N - 1;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // uart_tx model: busy for a few cycles after each start pulse
   initial begin
      logic [DW-1:0] d;
      int            n;
      int            ep;
      bus.txReady = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (bus.txValid === 1'b1) begin
            d  = bus.txData;
            ep = rst_epoch;
            got_q.push_back(d);
            bus.txReady = 1'b0;
            n = (busy_force > 0) ? busy_force : int'($urandom_range(2, 5));
            for (int i = 0; i < n; i++) begin
               @(posedge clk);
               #1;
               if (ep == rst_epoch && bus.txValid === 1'b1)
                  check("no_extra_valid", 32'(bus.txValid), 32'd0);
            end
            if (ep == rst_epoch)
               check("txdata_stable", 32'(bus.txData), 32'(d));
            bus.txReady = 1'b1;
         end
      end
   end

   // done monitor
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (|bus.done) begin
            check("done_onehot", $countones(bus.done), 32'd1);
            check("grant_at_done", 32'(bus.grant), 32'(bus.done));
            for (int r = 0; r < N; r++)
               if (bus.done[r]) done_q.push_back(r);
         end
      end
   end

   function automatic int rr_pick(input logic [N-1:0] pend);
      for (int k = 1; k <= N; k++) begin
         int p;
         p = (m_last + k) % N;
         if (pend[p]) return p;
      end
      return -1;
   endfunction

   task automatic wait_done(output int who);
      int t;
      who = -1;
      t = 0;
      while (done_q.size() == 0 && t < 4000) begin
         @(posedge clk);
         #2;
         t++;
      end
      if (done_q.size() == 0)
         check("done_timeout", 32'd1, 32'd0);
      else
         who = done_q.pop_front();
   endtask

   task automatic check_frame(input int who);
      logic [DW-1:0] e [$];
      if (HN > 0) begin
         e.push_back(8'hA5);
         e.push_back({4'(lens[who]), 4'(who)});
      end
      for (int i = 0; i < lens[who]; i++)
         e.push_back(mem[who][i]);
      check("frame_len", got_q.size(), e.size());
      foreach (e[i])
         if (i < got_q.size())
            check("frame_byte", 32'(got_q[i]), 32'(e[i]));
      got_q.delete();
   endtask

   task automatic set_lens();
      for (int r = 0; r < N; r++)
         bus.len[r*LW +: LW] = LW'(lens[r]);
   endtask

   task automatic serve(input logic [N-1:0] mask);
      logic [N-1:0] pend;
      int           who;
      int           exp;
      set_lens();
      pend = mask;
      bus.req = mask;
      for (int g = 0; g < N && pend != '0; g++) begin
         wait_done(who);
         exp = rr_pick(pend);
         check("rr_owner", who, exp);
         if (who < 0) break;
         check_frame(who);
         m_last = who;
         pend[who] = 1'b0;
         bus.req[who] = 1'b0;
      end
      bus.req = '0;
   endtask

   task automatic do_reset();
      rstN = 1'b0;
      rst_epoch++;
      repeat (3) @(posedge clk);
      #1;
      rstN = 1'b1;
      repeat (8) @(posedge clk);
      #2;
      got_q.delete();
      done_q.delete();
      m_last = N - 1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int who;
      int t;
      bus.req = '0;
      bus.len = '0;
      for (int r = 0; r < N; r++) begin
         lens[r] = 0;
         for (int i = 0; i < 16; i++) mem[r][i] = DW'($urandom);
      end

      // reset values
      rstN = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_grant", 32'(bus.grant), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_txvalid", 32'(bus.txValid), 32'd0);
      check("rst_txdata", 32'(bus.txData), 32'd0);
      check("rst_byteidx", 32'(bus.byteIdx), 32'd0);
      rstN = 1'b1;
      repeat (4) @(posedge clk);
      #2;

      // single 3-byte frame
      mem[0][0] = 8'h11;
      mem[0][1] = 8'h22;
      mem[0][2] = 8'h33;
      lens[0] = 3;
      serve(2'b01);

      // both requesting after reset: 0,1,0,1
      do_reset();
      lens[0] = 2;
      lens[1] = 1;
      set_lens();
      bus.req = 2'b11;
      for (int f = 0; f < 4; f++) begin
         wait_done(who);
         check("rr_order", who, f % 2);
         if (who >= 0) check_frame(who);
         m_last = who;
      end
      bus.req = '0;
      repeat (4) @(posedge clk);
      #2;

      // zero-length frame
      lens[0] = 0;
      set_lens();
      bus.req = 2'b01;
      t = 0;
      while (done_q.size() == 0 && t < 20) begin
         @(posedge clk);
         #2;
         t++;
      end
      check("zero_len_latency", 32'(t <= 3), 32'd1);
      if (done_q.size() > 0) who = done_q.pop_front();
      else who = -1;
      check("zero_len_owner", who, 32'd0);
      bus.req = '0;
      repeat (6) @(posedge clk);
      #2;
      check("zero_len_bytes", got_q.size(), HN);
      got_q.delete();
      m_last = 0;

`ifdef UART_FRAME_HEADER_EN
      // header frame from requester 1
      lens[1] = 2;
      serve(2'b10);
`endif

      // long uart busy period
      busy_force = 100;
      lens[1] = 3;
      serve(2'b10);
      busy_force = 0;

      // owner drops request mid-frame, frame still completes
      lens[0] = 3;
      set_lens();
      bus.req = 2'b01;
      t = 0;
      while (got_q.size() < HN + 1 && t < 500) begin
         @(posedge clk);
         #2;
         t++;
      end
      bus.req = '0;
      wait_done(who);
      check("drop_req_owner", who, 32'd0);
      if (who >= 0) check_frame(who);
      m_last = 0;

      // randomized masks and lengths
      for (int it = 0; it < 8; it++) begin
         for (int r = 0; r < N; r++) begin
            lens[r] = $urandom_range(0, 6);
            for (int i = 0; i < 16; i++) mem[r][i] = DW'($urandom);
         end
         serve(N'($urandom_range(1, 3)));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #2;
      end

      // reset while byte 2 of 4 is in flight
      do_reset();
      lens[0] = 4;
      set_lens();
      bus.req = 2'b01;
      t = 0;
      while (got_q.size() < HN + 2 && t < 500) begin
         @(posedge clk);
         #2;
         t++;
      end
      check("abort_reached_byte2", got_q.size(), HN + 2);
      rstN = 1'b0;
      rst_epoch++;
      bus.req = '0;
      repeat (2) @(posedge clk);
      #1;
      check("abort_grant", 32'(bus.grant), 32'd0);
      check("abort_txvalid", 32'(bus.txValid), 32'd0);
      check("abort_byteidx", 32'(bus.byteIdx), 32'd0);
      rstN = 1'b1;
      repeat (12) @(posedge clk);
      #2;
      check("abort_no_done", done_q.size(), 32'd0);
      got_q.delete();
      m_last = N - 1;
      serve(2'b01);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
